// File: rtl/reg_writeback_queue.sv
// Register-file write queue: two producers (A = ALU, B = load) merge into an in-order FIFO drained one write per cycle.
// Latency: an accepted request is presented on writeEn/writeAdd/writeData in the next cycle; lookups are same-cycle combinational.
// Backpressure: ready comes from occupancy alone (no credit for a same-cycle pop or an R0 drop); wbHold stalls the drain.
module reg_writeback_queue #(
  parameter int DEPTH   = 4,
  parameter bit DROP_R0 = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        aValid,
  input  logic [4:0]  aAdd,
  input  logic [31:0] aData,
  output logic        aReady,
  input  logic        bValid,
  input  logic [4:0]  bAdd,
  input  logic [31:0] bData,
  output logic        bReady,
  input  logic        wbHold,
  output logic [31:0] writeData,
  output logic [4:0]  writeAdd,
  output logic        writeEn,
  input  logic [4:0]  rdAdd1,
  input  logic [4:0]  rdAdd2,
  output logic        hit1,
  output logic        hit2,
  output logic [31:0] fwdData1,
  output logic [31:0] fwdData2
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] LIM1 = CW'(DEPTH - 1);
  localparam logic [CW-1:0] LIM2 = CW'(DEPTH - 2);

  typedef struct packed {
    logic [4:0]  add;
    logic [31:0] data;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] b_slot;
  logic [PW-1:0] lk_idx;
  logic          a_store, b_store, pop;

  // Handshake, store decisions and drain port; all derived from registered occupancy.
  always_comb begin
    aReady  = !rst && (count_q <= LIM1);
    bReady  = !rst && (aValid ? (count_q <= LIM2) : (count_q <= LIM1));
    // An accepted R0 write completes its handshake but is never stored.
    a_store = aValid && aReady && !(DROP_R0 && (aAdd == 5'd0));
    b_store = bValid && bReady && !(DROP_R0 && (bAdd == 5'd0));
    // B lands behind A when both are stored in the same cycle.
    b_slot  = tail_q + PW'(a_store);
    writeEn = !rst && !wbHold && (count_q != '0);
    pop     = writeEn;
    if (count_q != '0) begin
      writeAdd  = mem_q[head_q].add;
      writeData = mem_q[head_q].data;
    end else begin
      writeAdd  = '0;
      writeData = '0;
    end
    head_d  = head_q + PW'(pop);
    tail_d  = tail_q + PW'(a_store) + PW'(b_store);
    count_d = count_q + CW'(a_store) + CW'(b_store) - CW'(pop);
  end

  // Bypass lookup: walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    hit1     = 1'b0;
    hit2     = 1'b0;
    fwdData1 = '0;
    fwdData2 = '0;
    lk_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PW'(i);
      if (CW'(i) < count_q) begin
        if ((mem_q[lk_idx].add == rdAdd1) && !(DROP_R0 && (rdAdd1 == 5'd0))) begin
          hit1     = 1'b1;
          fwdData1 = mem_q[lk_idx].data;
        end
        if ((mem_q[lk_idx].add == rdAdd2) && !(DROP_R0 && (rdAdd2 == 5'd0))) begin
          hit2     = 1'b1;
          fwdData2 = mem_q[lk_idx].data;
        end
      end
    end
  end

  // Entry storage; slots beyond count are ignored, so contents need no reset.
  always_ff @(posedge clk) begin
    if (a_store) mem_q[tail_q] <= '{add: aAdd, data: aData};
    if (b_store) mem_q[b_slot] <= '{add: bAdd, data: bData};
  end

  // Pointer and occupancy state; reset discards everything queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Bench for reg_writeback_queue: scoreboard of accepted writes, checked against every drained write and every lookup.
// Directed phases cover reset, A/B ordering, full queue, R0 drop, wrap streaming and mid-run reset.
// Inputs change 1ns after the rising edge; the DUT is sampled on the falling edge.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        aValid, bValid, wbHold;
  logic [4:0]  aAdd, bAdd, rdAdd1, rdAdd2;
  logic [31:0] aData, bData;
  logic        aReady, bReady, writeEn, hit1, hit2;
  logic [31:0] writeData, fwdData1, fwdData2;
  logic [4:0]  writeAdd;

  typedef struct {
    logic [4:0]  add;
    logic [31:0] data;
  } wb_t;

  wb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(4), .DROP_R0(1'b1)) dut (
    .clk(clk), .rst(rst),
    .aValid(aValid), .aAdd(aAdd), .aData(aData), .aReady(aReady),
    .bValid(bValid), .bAdd(bAdd), .bData(bData), .bReady(bReady),
    .wbHold(wbHold),
    .writeData(writeData), .writeAdd(writeAdd), .writeEn(writeEn),
    .rdAdd1(rdAdd1), .rdAdd2(rdAdd2),
    .hit1(hit1), .hit2(hit2), .fwdData1(fwdData1), .fwdData2(fwdData2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard monitor: lookups, readies and drain port against the queued model, then model update.
  logic        e_hit1, e_hit2, e_we;
  logic [31:0] e_fwd1, e_fwd2;
  always @(negedge clk) begin
    if (mon_en) begin
      e_hit1 = 1'b0; e_fwd1 = '0; e_hit2 = 1'b0; e_fwd2 = '0;
      foreach (sb[k]) begin
        if (sb[k].add == rdAdd1 && rdAdd1 != 5'd0) begin e_hit1 = 1'b1; e_fwd1 = sb[k].data; end
        if (sb[k].add == rdAdd2 && rdAdd2 != 5'd0) begin e_hit2 = 1'b1; e_fwd2 = sb[k].data; end
      end
      check("m_hit1", 64'(hit1), 64'(e_hit1));
      check("m_fwd1", 64'(fwdData1), 64'(e_fwd1));
      check("m_hit2", 64'(hit2), 64'(e_hit2));
      check("m_fwd2", 64'(fwdData2), 64'(e_fwd2));
      check("m_aReady", 64'(aReady), 64'(!rst && sb.size() <= 3));
      check("m_bReady", 64'(bReady), 64'(!rst && (aValid ? sb.size() <= 2 : sb.size() <= 3)));
      e_we = !rst && !wbHold && (sb.size() != 0);
      check("m_writeEn", 64'(writeEn), 64'(e_we));
      if (sb.size() != 0) begin
        check("m_writeAdd", 64'(writeAdd), 64'(sb[0].add));
        check("m_writeData", 64'(writeData), 64'(sb[0].data));
      end else begin
        check("m_writeAdd_idle", 64'(writeAdd), 64'd0);
        check("m_writeData_idle", 64'(writeData), 64'd0);
      end
      if (e_we) void'(sb.pop_front());
      if (rst) begin
        sb.delete();
      end else begin
        if (aValid && aReady && aAdd != 5'd0) sb.push_back('{add: aAdd, data: aData});
        if (bValid && bReady && bAdd != 5'd0) sb.push_back('{add: bAdd, data: bData});
      end
    end
  end

  // Present A and/or B, holding each until accepted; returns 1ns after the last accepting edge.
  task automatic send(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic bv, input logic [4:0] ba, input logic [31:0] bd);
    bit a_done, b_done;
    int cyc;
    aValid = av; aAdd = aa; aData = ad;
    bValid = bv; bAdd = ba; bData = bd;
    a_done = !av; b_done = !bv; cyc = 0;
    while (!(a_done && b_done) && cyc < 50) begin
      @(negedge clk);
      if (aValid && aReady) a_done = 1'b1;
      if (bValid && bReady) b_done = 1'b1;
      @(posedge clk); #1;
      if (a_done) aValid = 1'b0;
      if (b_done) bValid = 1'b0;
      cyc++;
    end
    if (!(a_done && b_done)) begin
      check("send_timeout", 64'd0, 64'd1);
      aValid = 1'b0; bValid = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wbHold = 1'b0;
    aValid = 1'b0; aAdd = '0; aData = '0;
    bValid = 1'b0; bAdd = '0; bData = '0;
    rdAdd1 = 5'd5; rdAdd2 = 5'd3;

    // Reset: everything quiet once a reset edge has been seen.
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_writeEn", 64'(writeEn), 64'd0);
    check("rst_aReady", 64'(aReady), 64'd0);
    check("rst_bReady", 64'(bReady), 64'd0);
    check("rst_writeData", 64'(writeData), 64'd0);
    check("rst_hit1", 64'(hit1), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write: visible on the drain port and as a hit in the cycle after acceptance.
    send(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("single_writeEn", 64'(writeEn), 64'd1);
    check("single_writeAdd", 64'(writeAdd), 64'd5);
    check("single_writeData", 64'(writeData), 64'hDEADBEEF);
    check("single_hit1", 64'(hit1), 64'd1);
    @(negedge clk);
    check("single_after_writeEn", 64'(writeEn), 64'd0);
    check("single_after_hit1", 64'(hit1), 64'd0);

    // Simultaneous A/B to the same register: B is younger and wins the bypass.
    @(posedge clk); #1;
    wbHold = 1'b1; rdAdd1 = 5'd3;
    send(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    @(negedge clk);
    check("ab_hit1", 64'(hit1), 64'd1);
    check("ab_fwd1", 64'(fwdData1), 64'h22);
    check("ab_held", 64'(writeEn), 64'd0);
    @(posedge clk); #1;
    wbHold = 1'b0;
    @(negedge clk);
    check("ab_first", 64'(writeData), 64'h11);
    @(negedge clk);
    check("ab_second", 64'(writeData), 64'h22);
    @(negedge clk);
    check("ab_done", 64'(writeEn), 64'd0);

    // Full queue: readies follow occupancy, then four back-to-back writes.
    @(posedge clk); #1;
    wbHold = 1'b1;
    send(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
    send(1'b1, 5'd3, 32'hA3, 1'b0, 5'd0, 32'd0);
    aValid = 1'b1; aAdd = 5'd4; aData = 32'hA4;
    @(negedge clk);
    check("cnt3_aReady", 64'(aReady), 64'd1);
    check("cnt3_bReady", 64'(bReady), 64'd0);
    @(posedge clk); #1;
    aValid = 1'b0;
    @(negedge clk);
    check("full_aReady", 64'(aReady), 64'd0);
    check("full_bReady", 64'(bReady), 64'd0);
    @(posedge clk); #1;
    wbHold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("full_drain_en", 64'(writeEn), 64'd1);
      check("full_drain_add", 64'(writeAdd), 64'(k + 1));
      if (k == 0) check("full_drain_noready", 64'(aReady), 64'd0);
    end
    @(negedge clk);
    check("full_drained", 64'(writeEn), 64'd0);

    // R0 drop: handshake completes but no slot is taken.
    @(posedge clk); #1;
    wbHold = 1'b1; rdAdd1 = 5'd0;
    send(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 32'd0);
    send(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
    @(negedge clk);
    check("r0_hit1", 64'(hit1), 64'd0);
    @(posedge clk); #1;
    send(1'b1, 5'd7, 32'h77, 1'b1, 5'd8, 32'h88);
    @(negedge clk);
    check("r0_count3_aReady", 64'(aReady), 64'd1);
    check("r0_count3_bReady", 64'(bReady), 64'd1);
    @(posedge clk); #1;
    wbHold = 1'b0;
    idle(6);

    // Streaming with B on odd requests: pointers wrap many times.
    for (int i = 0; i < 10; i++) begin
      rdAdd1 = 5'($urandom_range(0, 31));
      rdAdd2 = 5'(i + 16);
      send(1'b1, 5'(i), 32'(i), 1'(i % 2), 5'(i + 16), 32'h100 + 32'(i));
    end
    idle(12);
    check("stream_drained", 64'(sb.size()), 64'd0);

    // Reset with three entries queued: nothing stale survives.
    wbHold = 1'b1; rdAdd1 = 5'd7; rdAdd2 = 5'd8;
    send(1'b1, 5'd7, 32'h70, 1'b1, 5'd8, 32'h80);
    send(1'b1, 5'd9, 32'h90, 1'b0, 5'd0, 32'd0);
    rst = 1'b1; wbHold = 1'b0;
    @(negedge clk);
    check("midrst_writeEn", 64'(writeEn), 64'd0);
    check("midrst_aReady", 64'(aReady), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("postrst_writeEn", 64'(writeEn), 64'd0);
    check("postrst_hit1", 64'(hit1), 64'd0);
    check("postrst_hit2", 64'(hit2), 64'd0);
    idle(3);
    check("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
